// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the Enter/Clear buttons and the switch bus for the calculator.
// Optional auto-repeat of EnterPulse is built only when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int SW_WIDTH          = 12
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY      = 25000000,
    parameter int REPEAT_PERIOD     = 5000000
`endif
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                KeyEnterRaw,
    input  logic                KeyClearRaw,
    input  logic [SW_WIDTH-1:0] SwitchsRaw,
    output logic                Enter,
    output logic                Clear,
    output logic                EnterPulse,
    output logic                ClearPulse,
    output logic [SW_WIDTH-1:0] Switchs,
    output logic                SwitchsValid
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING,
        LOCKOUT
    } key_state_e;

    logic [1:0]          enter_sync_q, clear_sync_q;
    logic                enter_s, clear_s, clear_commit;
    key_state_e          enter_st_q, clear_st_q;
    logic [CW-1:0]       enter_cnt_q, clear_cnt_q, sw_cnt_q;
    logic                enter_q, clear_q, enter_pulse_q, clear_pulse_q;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q, sw_prev_q, switchs_q;
    logic                valid_q;
`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0]       rep_q;
`endif

    assign enter_s      = enter_sync_q[1];
    assign clear_s      = clear_sync_q[1];
    assign clear_commit = clear_st_q == PRESS_PENDING && clear_s && clear_cnt_q == LAST;

    // Two-flop synchronisers; buttons are normalised to pressed=1 before sampling, so reset means released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enter_sync_q <= '0;
            clear_sync_q <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            enter_sync_q <= {enter_sync_q[0], KeyEnterRaw ^ BUTTON_ACTIVE_LOW};
            clear_sync_q <= {clear_sync_q[0], KeyClearRaw ^ BUTTON_ACTIVE_LOW};
            sw_meta_q    <= SwitchsRaw;
            sw_sync_q    <= sw_meta_q;
        end
    end

    // Enter debounce FSM; a press that commits while Clear is high or committing is swallowed into LOCKOUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enter_st_q    <= RELEASED;
            enter_cnt_q   <= '0;
            enter_q       <= 1'b0;
            enter_pulse_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            enter_pulse_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
            case (enter_st_q)
                RELEASED: if (enter_s) begin
                    enter_st_q  <= PRESS_PENDING;
                    enter_cnt_q <= CW'(1);
                end
                PRESS_PENDING: if (!enter_s) begin
                    enter_st_q  <= RELEASED;
                    enter_cnt_q <= '0;
                end else if (enter_cnt_q == LAST) begin
                    enter_cnt_q <= '0;
                    if (clear_q || clear_commit) enter_st_q <= LOCKOUT;
                    else begin
                        enter_st_q    <= PRESSED;
                        enter_q       <= 1'b1;
                        enter_pulse_q <= 1'b1;
                    end
                end else enter_cnt_q <= enter_cnt_q + CW'(1);
                PRESSED: if (!enter_s) begin
                    enter_st_q  <= RELEASE_PENDING;
                    enter_cnt_q <= CW'(1);
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rep_q == REP_LAST) begin
                    enter_pulse_q <= 1'b1;
                    rep_q         <= REP_RELOAD;
                end else rep_q <= rep_q + RW'(1);
`endif
                RELEASE_PENDING: if (enter_s) begin
                    enter_st_q  <= PRESSED;
                    enter_cnt_q <= '0;
                end else if (enter_cnt_q == LAST) begin
                    enter_st_q  <= RELEASED;
                    enter_cnt_q <= '0;
                    enter_q     <= 1'b0;
                end else enter_cnt_q <= enter_cnt_q + CW'(1);
                default: if (enter_s) enter_cnt_q <= '0;
                else if (enter_cnt_q == LAST) begin
                    enter_st_q  <= RELEASED;
                    enter_cnt_q <= '0;
                end else enter_cnt_q <= enter_cnt_q + CW'(1);
            endcase
        end
    end

    // Clear debounce FSM; Clear always wins and never repeats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clear_st_q    <= RELEASED;
            clear_cnt_q   <= '0;
            clear_q       <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            clear_pulse_q <= 1'b0;
            case (clear_st_q)
                RELEASED: if (clear_s) begin
                    clear_st_q  <= PRESS_PENDING;
                    clear_cnt_q <= CW'(1);
                end
                PRESS_PENDING: if (!clear_s) begin
                    clear_st_q  <= RELEASED;
                    clear_cnt_q <= '0;
                end else if (clear_cnt_q == LAST) begin
                    clear_st_q    <= PRESSED;
                    clear_cnt_q   <= '0;
                    clear_q       <= 1'b1;
                    clear_pulse_q <= 1'b1;
                end else clear_cnt_q <= clear_cnt_q + CW'(1);
                PRESSED: if (!clear_s) begin
                    clear_st_q  <= RELEASE_PENDING;
                    clear_cnt_q <= CW'(1);
                end
                default: if (clear_s) begin
                    clear_st_q  <= PRESSED;
                    clear_cnt_q <= '0;
                end else if (clear_cnt_q == LAST) begin
                    clear_st_q  <= RELEASED;
                    clear_cnt_q <= '0;
                    clear_q     <= 1'b0;
                end else clear_cnt_q <= clear_cnt_q + CW'(1);
            endcase
        end
    end

    // Whole-word switch debounce; the output only reloads while Enter is released so captures stay glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_prev_q <= '0;
            sw_cnt_q  <= '0;
            switchs_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            sw_prev_q <= sw_sync_q;
            if (sw_sync_q != sw_prev_q) sw_cnt_q <= '0;
            else if (sw_cnt_q != LAST) sw_cnt_q <= sw_cnt_q + CW'(1);
            if (sw_sync_q == sw_prev_q && sw_cnt_q == LAST && !enter_q) begin
                switchs_q <= sw_sync_q;
                valid_q   <= 1'b1;
            end
        end
    end

    assign Enter        = enter_q;
    assign Clear        = clear_q;
    assign EnterPulse   = enter_pulse_q;
    assign ClearPulse   = clear_pulse_q;
    assign Switchs      = switchs_q;
    assign SwitchsValid = valid_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, bounce rejection, switch freeze, Clear priority and reset.
module tb_key_conditioner;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        KeyEnterRaw = 1'b0;
    logic        KeyClearRaw = 1'b1;
    logic [11:0] SwitchsRaw = '0;
    logic        Enter, Clear, EnterPulse, ClearPulse, SwitchsValid;
    logic [11:0] Switchs;
    int checks = 0;
    int errors = 0;
    int ep_cnt = 0;
    int cp_cnt = 0;

    key_conditioner #(.DEBOUNCE_CYCLES(4), .BUTTON_ACTIVE_LOW(1'b1), .SW_WIDTH(12)) dut (
        .clock(clock), .reset_n(reset_n), .KeyEnterRaw(KeyEnterRaw), .KeyClearRaw(KeyClearRaw),
        .SwitchsRaw(SwitchsRaw), .Enter(Enter), .Clear(Clear), .EnterPulse(EnterPulse),
        .ClearPulse(ClearPulse), .Switchs(Switchs), .SwitchsValid(SwitchsValid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ep_cnt += int'(EnterPulse);
            cp_cnt += int'(ClearPulse);
        end
    endtask

    initial begin
        // 1: reset with Enter held, then clean press committing on the 6th edge
        step(3);
        check("rst_enter", Enter, 0);
        check("rst_clear", Clear, 0);
        check("rst_epulse", EnterPulse, 0);
        check("rst_cpulse", ClearPulse, 0);
        check("rst_sw", Switchs, 0);
        check("rst_valid", SwitchsValid, 0);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            check($sformatf("t1_enter_e%0d", i), Enter, i >= 6);
            check($sformatf("t1_pulse_e%0d", i), EnterPulse, i == 6);
        end
        KeyEnterRaw = 1'b1;
        step(10);
        check("t1_released", Enter, 0);
        // 2: bounce every 2 cycles never survives 4 stable cycles
        ep_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            KeyEnterRaw = ~KeyEnterRaw;
            step(2);
            check("t2_bounce_enter", Enter, 0);
        end
        KeyEnterRaw = 1'b1;
        step(10);
        check("t2_enter", Enter, 0);
        check("t2_pulses", ep_cnt, 0);
        // 3: switch load, freeze while Enter held, reload one edge after Enter falls
        SwitchsRaw = 12'h0A5;
        step(10);
        check("t3_sw", Switchs, 12'h0A5);
        check("t3_valid", SwitchsValid, 1);
        KeyEnterRaw = 1'b0;
        step(8);
        check("t3_enter", Enter, 1);
        SwitchsRaw = 12'h3FF;
        step(10);
        check("t3_frozen", Switchs, 12'h0A5);
        KeyEnterRaw = 1'b1;
        for (int i = 0; i < 20 && Enter !== 1'b0; i++) @(negedge clock);
        check("t3_enter_fell", Enter, 0);
        check("t3_still_frozen", Switchs, 12'h0A5);
        @(negedge clock);
        check("t3_reload", Switchs, 12'h3FF);
        // 4: simultaneous press -> Clear wins, Enter locked out until released
        ep_cnt = 0;
        cp_cnt = 0;
        KeyEnterRaw = 1'b0;
        KeyClearRaw = 1'b0;
        step(10);
        check("t4_clear", Clear, 1);
        check("t4_enter", Enter, 0);
        check("t4_cpulses", cp_cnt, 1);
        check("t4_epulses", ep_cnt, 0);
        KeyEnterRaw = 1'b1;
        KeyClearRaw = 1'b1;
        step(12);
        check("t4_clear_rel", Clear, 0);
        check("t4_enter_rel", Enter, 0);
        ep_cnt = 0;
        KeyEnterRaw = 1'b0;
        step(10);
        check("t4_repress", Enter, 1);
        check("t4_repress_pulses", ep_cnt, 1);
        cp_cnt = 0;
        ep_cnt = 0;
        KeyClearRaw = 1'b0;
        step(10);
        check("t4_both_clear", Clear, 1);
        check("t4_both_enter", Enter, 1);
        check("t4_both_cpulses", cp_cnt, 1);
        check("t4_both_epulses", ep_cnt, 0);
        KeyClearRaw = 1'b1;
        step(10);
        check("t4_clear_off", Clear, 0);
        check("t4_enter_held", Enter, 1);
        // 5: async reset mid-press with key still held, then requalify
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_enter", Enter, 0);
        check("t5_async_sw", Switchs, 0);
        check("t5_async_valid", SwitchsValid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            check($sformatf("t5_enter_e%0d", i), Enter, i >= 6);
            check($sformatf("t5_pulse_e%0d", i), EnterPulse, i == 6);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
